// File: rtl/audio_fx_i2s.sv
// -----------------------------------------------------------------------------
// audio_fx_i2s
//
// Sound-effect engine for the game audio path. Game event pulses are latched
// into a pending register. On every audio frame boundary the highest-priority
// pending event is selected, and a square-wave tone is played for a fixed
// number of frames. The resulting sample is serialised in I2S format, with the
// same value on the left and right channels, straight to the WM8731 DAC pins.
//
// Optional feature macro: AUDIO_ENVELOPE_EN
//   defined   -> the tone magnitude decays in four steps (AMPLITUDE >> 0..3)
//                over the length of the tone.
//   undefined -> the magnitude is the constant AMPLITUDE, and no envelope
//                logic is built.
//
// Ports
//   clk          in   system clock; all logic runs on the rising edge
//   reset        in   synchronous, active-high
//   event_in     in   [NUM_EVENTS] one-clk event pulses; higher index wins
//   aud_bclk     out  I2S bit clock (2*BCLK_DIV clk period)
//   aud_daclrck  out  left/right clock, 0 = left, 128*BCLK_DIV clk period
//   aud_dacdat   out  serial sample data, MSB first, one BCLK after LRCK edge
//   busy         out  a tone is playing
//   active_event out  index of the playing event
// -----------------------------------------------------------------------------
module audio_fx_i2s #(
    parameter int          NUM_EVENTS   = 5,
    parameter int          SAMPLE_WIDTH = 16,
    parameter int          BCLK_DIV     = 2,
    parameter int unsigned AMPLITUDE    = 16'h2000,
    parameter int          TONE_SAMPLES = 4800,
    parameter int          HALF_BASE    = 24,
    parameter int          HALF_STEP    = 4,
    localparam int         EV_W         = (NUM_EVENTS > 1) ? $clog2(NUM_EVENTS) : 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_EVENTS-1:0] event_in,
    output logic                  aud_bclk,
    output logic                  aud_daclrck,
    output logic                  aud_dacdat,
    output logic                  busy,
    output logic [EV_W-1:0]       active_event
);

    localparam int DIV_W = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
    localparam int CNT_W = $clog2(TONE_SAMPLES);
    localparam int H_MAX = HALF_BASE + (NUM_EVENTS - 1) * HALF_STEP;
    localparam int PH_W  = (H_MAX > 1) ? $clog2(H_MAX) : 1;

    localparam logic [SAMPLE_WIDTH-1:0] AMP_SW = SAMPLE_WIDTH'(AMPLITUDE);

`ifdef AUDIO_ENVELOPE_EN
    // Thresholds on 4*sample_cnt that select the decay step q = floor(4*cnt/T).
    localparam logic [CNT_W+1:0] ENV_Q1 = (CNT_W + 2)'(TONE_SAMPLES);
    localparam logic [CNT_W+1:0] ENV_Q2 = (CNT_W + 2)'(2 * TONE_SAMPLES);
    localparam logic [CNT_W+1:0] ENV_Q3 = (CNT_W + 2)'(3 * TONE_SAMPLES);
`endif

    // Bit-clock divider and half-BCLK position within the frame (0..127).
    // Bit 0 of the position is BCLK, and bit 6 is LRCK.
    logic [DIV_W-1:0]        div_cnt_q, div_cnt_d;
    logic [6:0]              half_q, half_d;

    // Serialiser
    logic [31:0]             shift_q, shift_d;
    logic                    dacdat_q, dacdat_d;
    logic [SAMPLE_WIDTH-1:0] sample_q, sample_d;

    // Event and tone state
    logic [NUM_EVENTS-1:0]   pending_q, pending_d;
    logic                    busy_q, busy_d;
    logic [EV_W-1:0]         active_q, active_d;
    logic [CNT_W-1:0]        sample_cnt_q, sample_cnt_d;
    logic [PH_W-1:0]         phase_q, phase_d;
    logic                    level_q, level_d;

    // Combinational helpers
    logic                    frame_tick;
    logic                    bclk_fall;
    logic                    load_left;
    logic                    load_right;
    logic                    top_valid;
    logic [EV_W-1:0]         top_idx;
    logic                    tone_last;
    logic                    start_new;
    logic [31:0]             half_m1;
    logic [SAMPLE_WIDTH-1:0] magnitude;
    logic [SAMPLE_WIDTH-1:0] sample_val;
`ifdef AUDIO_ENVELOPE_EN
    logic [CNT_W+1:0]        cnt_x4;
`endif

    // -------------------------------------------------------------------------
    // Frame timing
    // -------------------------------------------------------------------------
    always_comb begin
        div_cnt_d = div_cnt_q + DIV_W'(1);
        half_d    = half_q;
        if (div_cnt_q == DIV_W'(BCLK_DIV - 1)) begin
            div_cnt_d = '0;
            half_d    = half_q + 7'd1;   // wraps to 0 at the end of a frame
        end
    end

    // The frame tick is the first clk of a frame. This is also the first clk
    // out of reset, because the dividers reset to zero.
    assign frame_tick = (div_cnt_q == '0) && (half_q == 7'd0);
    // The edge that ends an odd half-period is a BCLK falling edge.
    assign bclk_fall  = (div_cnt_q == DIV_W'(BCLK_DIV - 1)) && half_q[0];
    // Loads land on the clk after each LRCK transition. That clk is never a
    // falling edge because BCLK is still low there.
    assign load_left  = (div_cnt_q == DIV_W'(1)) && (half_q == 7'd0);
    assign load_right = (div_cnt_q == DIV_W'(1)) && (half_q == 7'd64);

    // -------------------------------------------------------------------------
    // Arbitration: select the highest set pending bit.
    // -------------------------------------------------------------------------
    always_comb begin
        top_valid = 1'b0;
        top_idx   = '0;
        for (int i = 0; i < NUM_EVENTS; i++) begin
            if (pending_q[i]) begin
                top_valid = 1'b1;
                top_idx   = EV_W'(i);
            end
        end
    end

    always_comb begin
        tone_last = busy_q && (sample_cnt_q == CNT_W'(TONE_SAMPLES - 1));
        // A finishing tone counts as idle, so a waiting event starts on the
        // same tick without a silent frame.
        start_new = frame_tick && top_valid &&
                    (!busy_q || tone_last || (top_idx > active_q));
        half_m1   = 32'(HALF_BASE) + 32'(active_q) * 32'(HALF_STEP) - 32'd1;

        // New event pulses override the clear of the started event.
        for (int i = 0; i < NUM_EVENTS; i++) begin
            pending_d[i] = event_in[i] |
                           (pending_q[i] & ~(start_new && (top_idx == EV_W'(i))));
        end

        busy_d       = busy_q;
        active_d     = active_q;
        sample_cnt_d = sample_cnt_q;
        phase_d      = phase_q;
        level_d      = level_q;

        if (start_new) begin
            busy_d       = 1'b1;
            active_d     = top_idx;
            sample_cnt_d = '0;
            phase_d      = '0;
            level_d      = 1'b1;
        end else if (frame_tick && tone_last) begin
            busy_d = 1'b0;
        end else if (frame_tick && busy_q) begin
            sample_cnt_d = sample_cnt_q + CNT_W'(1);
            if (32'(phase_q) == half_m1) begin
                phase_d = '0;
                level_d = ~level_q;
            end else begin
                phase_d = phase_q + PH_W'(1);
            end
        end
    end

    // -------------------------------------------------------------------------
    // Sample value
    // -------------------------------------------------------------------------
    always_comb begin
        magnitude = AMP_SW;
`ifdef AUDIO_ENVELOPE_EN
        cnt_x4 = {sample_cnt_q, 2'b00};
        if (cnt_x4 >= ENV_Q3) begin
            magnitude = AMP_SW >> 3;
        end else if (cnt_x4 >= ENV_Q2) begin
            magnitude = AMP_SW >> 2;
        end else if (cnt_x4 >= ENV_Q1) begin
            magnitude = AMP_SW >> 1;
        end
`endif
        if (!busy_q) begin
            sample_val = '0;
        end else if (level_q) begin
            sample_val = magnitude;
        end else begin
            sample_val = -magnitude;
        end
    end

    // -------------------------------------------------------------------------
    // Serialiser: left-justify each sample in a 32-bit slot. Shift one bit
    // out on every BCLK falling edge. After each load, the first falling edge
    // is one BCLK past the LRCK edge, and it carries the MSB.
    // -------------------------------------------------------------------------
    always_comb begin
        shift_d  = shift_q;
        dacdat_d = dacdat_q;
        sample_d = sample_q;
        if (load_left) begin
            sample_d = sample_val;
            shift_d  = 32'(sample_val) << (32 - SAMPLE_WIDTH);
        end else if (load_right) begin
            shift_d  = 32'(sample_q) << (32 - SAMPLE_WIDTH);
        end else if (bclk_fall) begin
            dacdat_d = shift_q[31];
            shift_d  = {shift_q[30:0], 1'b0};
        end
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            div_cnt_q    <= '0;
            half_q       <= '0;
            shift_q      <= '0;
            dacdat_q     <= 1'b0;
            sample_q     <= '0;
            pending_q    <= '0;
            busy_q       <= 1'b0;
            active_q     <= '0;
            sample_cnt_q <= '0;
            phase_q      <= '0;
            level_q      <= 1'b0;
        end else begin
            div_cnt_q    <= div_cnt_d;
            half_q       <= half_d;
            shift_q      <= shift_d;
            dacdat_q     <= dacdat_d;
            sample_q     <= sample_d;
            pending_q    <= pending_d;
            busy_q       <= busy_d;
            active_q     <= active_d;
            sample_cnt_q <= sample_cnt_d;
            phase_q      <= phase_d;
            level_q      <= level_d;
        end
    end

    assign aud_bclk     = half_q[0];
    assign aud_daclrck  = half_q[6];
    assign aud_dacdat   = dacdat_q;
    assign busy         = busy_q;
    assign active_event = active_q;

endmodule

// File: tb/tb_audio_fx_i2s.sv
// -----------------------------------------------------------------------------
// tb_audio_fx_i2s
//
// The stimulus process walks the DUT frame by frame, with random pulse
// timing inside each frame. It advances a frame-level reference model and
// pushes the expected sample, busy and active_event for every frame into a
// queue. A monitor decodes the I2S stream like a DAC would, then pops and
// compares each decoded frame. The monitor also checks BCLK/LRCK periods,
// zero slot padding and reset values.
// -----------------------------------------------------------------------------
module tb_audio_fx_i2s;

    localparam int NE   = 5;
    localparam int SW   = 16;
    localparam int BDIV = 2;
    localparam int AMP  = 16'h2000;
    localparam int TS   = 8;
    localparam int HB   = 2;
    localparam int HS   = 1;
    localparam int F    = 128 * BDIV;   // clks per frame

    logic          clk;
    logic          reset;
    logic [NE-1:0] event_in;
    logic          aud_bclk;
    logic          aud_daclrck;
    logic          aud_dacdat;
    logic          busy;
    logic [2:0]    active_event;

    audio_fx_i2s #(
        .NUM_EVENTS   (NE),
        .SAMPLE_WIDTH (SW),
        .BCLK_DIV     (BDIV),
        .AMPLITUDE    (AMP),
        .TONE_SAMPLES (TS),
        .HALF_BASE    (HB),
        .HALF_STEP    (HS)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .event_in     (event_in),
        .aud_bclk     (aud_bclk),
        .aud_daclrck  (aud_daclrck),
        .aud_dacdat   (aud_dacdat),
        .busy         (busy),
        .active_event (active_event)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [SW-1:0] smp;
        bit            busy;
        int            active;
    } exp_t;

    exp_t exp_q[$];
    bit   done;
    int   checks;
    int   errors;

    // ---------------------------------------------------------------------
    // Reference model, at frame granularity
    // ---------------------------------------------------------------------
    bit [NE-1:0] m_pending;
    bit          m_busy;
    int          m_active;
    int          m_n;        // frames since the current tone started

    function automatic void model_tick();
        int top;
        top = -1;
        for (int i = 0; i < NE; i++) if (m_pending[i]) top = i;
        if (m_busy && m_n == TS - 1) m_busy = 1'b0;
        if (top >= 0 && (!m_busy || top > m_active)) begin
            m_busy       = 1'b1;
            m_active     = top;
            m_n          = 0;
            m_pending[top] = 1'b0;
        end else if (m_busy) begin
            m_n++;
        end
    endfunction

    function automatic logic [SW-1:0] model_sample();
        int h;
        int q;
        logic [SW-1:0] mag;
        if (!m_busy) return '0;
        h = HB + m_active * HS;
        q = 0;
`ifdef AUDIO_ENVELOPE_EN
        q = (4 * m_n) / TS;
`endif
        mag = SW'(AMP >> q);
        if (((m_n / h) % 2) == 0) return mag;
        return SW'(0) - mag;
    endfunction

    // ---------------------------------------------------------------------
    // Stimulus. Each task is entered exactly on a frame-tick clock edge.
    // ---------------------------------------------------------------------
    task automatic push_frame();
        exp_t e;
        model_tick();
        e.smp    = model_sample();
        e.busy   = m_busy;
        e.active = m_active;
        exp_q.push_back(e);
    endtask

    task automatic run_frame(input logic [NE-1:0] ev);
        int r;
        push_frame();
        if (ev != '0) begin
            r = int'($urandom_range(0, F - 2));
            repeat (r) @(posedge clk);
            #1 event_in = ev;
            @(posedge clk);
            #1 event_in = '0;
            m_pending = m_pending | ev;
            repeat (F - r - 1) @(posedge clk);
        end else begin
            repeat (F) @(posedge clk);
        end
    endtask

    task automatic do_reset();
        #1 reset = 1'b1;
        event_in = '0;
        repeat (3) @(posedge clk);
        #1;
        m_pending = '0;
        m_busy    = 1'b0;
        m_active  = 0;
        m_n       = 0;
        reset     = 1'b0;
        @(posedge clk);            // first frame tick after reset
    endtask

    initial begin
        logic [NE-1:0] ev;
        reset    = 1'b1;
        event_in = '0;
        done     = 1'b0;
        do_reset();

        // Idle after reset
        repeat (3) run_frame('0);

        // Single event 0
        run_frame(5'b00001);
        repeat (10) run_frame('0);

        // Priority: events 1 and 3 pulsed together
        run_frame(5'b01010);
        repeat (18) run_frame('0);

        // Preemption of event 2 by event 4, with no replay of event 2
        run_frame(5'b00100);
        run_frame('0);
        run_frame('0);
        run_frame(5'b10000);
        repeat (12) run_frame('0);

        // Preemption with event 2 re-triggered while it plays, so it replays
        run_frame(5'b00100);
        run_frame(5'b00100);
        run_frame(5'b10000);
        repeat (20) run_frame('0);

        // Random event traffic
        repeat (50) begin
            ev = ($urandom_range(0, 2) == 0) ? NE'($urandom) : '0;
            run_frame(ev);
        end
        repeat (42) run_frame('0);

        // Reset during frame 3 of a tone, with a replay of the event queued
        run_frame(5'b00001);
        run_frame('0);
        run_frame('0);
        run_frame(5'b00001);
        push_frame();
        repeat (100) @(posedge clk);
        do_reset();
        repeat (12) run_frame('0);

        done = 1'b1;
    end

    // ---------------------------------------------------------------------
    // Monitor: I2S decoder plus scoreboard, sampled on falling clk edges
    // ---------------------------------------------------------------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    initial begin
        int            rst_cnt;
        int            frames;
        int            dec_j;
        bit            dec_prev_lrck;
        logic [SW-1:0] dec_sr;
        logic [SW-1:0] left_s;
        logic [SW-1:0] right_s;
        logic          bclk_prev;
        logic          lrck_prev;
        int            bclk_run;
        int            lrck_run;
        bit            bclk_seen;
        bit            lrck_seen;
        exp_t          e;

        checks  = 0;
        errors  = 0;
        rst_cnt = 0;
        frames  = 0;
        dec_j   = 0;
        dec_prev_lrck = 1'b1;
        dec_sr  = '0;
        left_s  = '0;
        right_s = '0;
        bclk_prev = 1'b0;
        lrck_prev = 1'b0;
        bclk_run  = 0;
        lrck_run  = 0;
        bclk_seen = 1'b0;
        lrck_seen = 1'b0;

        forever begin
            @(negedge clk);
            if (done) begin
                chk("queue_drained", 32'(exp_q.size()), 32'd0);
                $display("CHECKS %0d ERRORS %0d", checks, errors);
                $finish;
            end else if (reset) begin
                rst_cnt++;
                if (rst_cnt >= 2) begin
                    chk("rst_bclk", 32'(aud_bclk), 32'd0);
                    chk("rst_lrck", 32'(aud_daclrck), 32'd0);
                    chk("rst_dacdat", 32'(aud_dacdat), 32'd0);
                    chk("rst_busy", 32'(busy), 32'd0);
                    chk("rst_active", 32'(active_event), 32'd0);
                end
                exp_q.delete();
                dec_prev_lrck = 1'b1;
                dec_j     = 0;
                dec_sr    = '0;
                bclk_prev = 1'b0;
                lrck_prev = 1'b0;
                bclk_run  = 0;
                lrck_run  = 0;
                bclk_seen = 1'b0;
                lrck_seen = 1'b0;
            end else begin
                rst_cnt = 0;
                bclk_run++;
                lrck_run++;
                if (aud_daclrck !== lrck_prev) begin
                    if (lrck_seen) chk("lrck_half_period", 32'(lrck_run), 32'(64 * BDIV));
                    lrck_seen = 1'b1;
                    lrck_run  = 0;
                end
                if (aud_bclk !== bclk_prev) begin
                    if (bclk_seen) chk("bclk_half_period", 32'(bclk_run), 32'(BDIV));
                    bclk_seen = 1'b1;
                    bclk_run  = 0;
                    if (aud_bclk) begin
                        if (aud_daclrck != dec_prev_lrck) dec_j = 0;
                        else dec_j++;
                        dec_prev_lrck = aud_daclrck;
                        if (dec_j >= 1 && dec_j <= SW) begin
                            dec_sr = {dec_sr[SW-2:0], aud_dacdat};
                            if (dec_j == SW) begin
                                if (!aud_daclrck) begin
                                    left_s = dec_sr;
                                end else begin
                                    right_s = dec_sr;
                                    frames++;
                                    $display("frame %0d L=%h R=%h busy=%0d event=%0d",
                                             frames, left_s, right_s, busy, active_event);
                                    if (exp_q.size() == 0) begin
                                        checks++;
                                        errors++;
                                        $display("FAIL unexpected_frame actual=frame %0d required=none queued", frames);
                                    end else begin
                                        e = exp_q.pop_front();
                                        chk("left_sample", 32'(left_s), 32'(e.smp));
                                        chk("right_sample", 32'(right_s), 32'(e.smp));
                                        chk("busy", 32'(busy), 32'(e.busy));
                                        if (e.busy) chk("active_event", 32'(active_event), 32'(e.active));
                                    end
                                end
                            end
                        end else begin
                            chk("slot_padding", 32'(aud_dacdat), 32'd0);
                        end
                    end
                end
                bclk_prev = aud_bclk;
                lrck_prev = aud_daclrck;
            end
        end
    end

endmodule

// File: doc/audio_fx_i2s.md
# audio_fx_i2s

Parametrised sound-effect engine for the game audio path. It latches game event pulses (wall hit, paddle hit, point, win, level up, or any NUM_EVENTS-wide set) and arbitrates them by priority. For the winning event it plays a square-wave tone for a fixed number of samples. The tone is serialised in I2S format straight to the WM8731 DAC pins (BCLK, DACLRCK, DACDAT); the codec master clock (XCK) and I2C configuration are generated elsewhere.

## Interface
Parameters:
- NUM_EVENTS, 5: number of event inputs; bit NUM_EVENTS-1 has highest priority.
- SAMPLE_WIDTH, 16: signed sample width, 1..32.
- BCLK_DIV, 2: clk cycles per BCLK half-period, ≥2.
- AMPLITUDE, 16'h2000: peak magnitude, < 2^(SAMPLE_WIDTH-1).
- TONE_SAMPLES, 4800: tone length in samples (frames), ≥4.
- HALF_BASE, 24: square-wave half-period in samples for event 0, ≥1.
- HALF_STEP, 4: extra half-period samples per event index.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high.
- event_in  in  NUM_EVENTS  one-clk event pulses.
- aud_bclk  out  1  I2S bit clock.
- aud_daclrck  out  1  left/right clock; 0 = left.
- aud_dacdat  out  1  serial data, MSB first.
- busy  out  1  tone playing.
- active_event  out  $clog2(NUM_EVENTS)  index of the playing event.

## Operation
- **Pending register:** any event_in bit set ORs into pending[NUM_EVENTS-1:0]. If a set and a clear of the same bit land in one cycle, set wins.
- **Frame tick:** one-clk strobe on the cycle aud_daclrck goes 1→0 (start of the left channel).
- **Arbitration** happens on the frame tick only:
  - If idle and pending≠0, take the highest set index i, clear pending[i], set busy=1, active_event=i, sample_cnt=0, phase_cnt=0, level=1.
  - If busy and a pending index > active_event exists, preempt: load it the same way.
  - Lower or equal pending events wait. Re-triggering the playing event queues one replay.
- **Tone:** half-period H(i)=HALF_BASE+i·HALF_STEP samples.
  - Per frame while busy: phase_cnt increments; when phase_cnt reaches H(i)-1 it wraps to 0 and level toggles.
  - sample_cnt increments each frame; when it reaches TONE_SAMPLES-1, the next tick returns to idle, or arbitrates immediately if pending≠0.
- **Sample value:** +AMPLITUDE when level=1, −AMPLITUDE (two's complement) when level=0, 0 when idle. The same value is sent on left and right.
- **Serialiser (I2S):**
  - 32 BCLKs per channel, 64 per frame.
  - aud_dacdat changes on BCLK falling edges. The MSB is driven on the first falling edge after the LRCK transition, i.e. one BCLK delay.
  - SAMPLE_WIDTH bits are sent, then zeros to slot end.
- **Reset:** clears pending, tone state and dividers. A reset mid-tone drops the tone and all pending events.

## Timing
- Reset values:
  - aud_bclk=0, aud_daclrck=0, aud_dacdat=0.
  - busy=0, active_event=0, pending=0.
- The first frame starts at the first clk after reset deasserts; that cycle is a frame tick.
- BCLK period is 2·BCLK_DIV clks. Frame period is 128·BCLK_DIV clks.
- Sample latching and serialisation:
  - The sample is latched into the shift register 1 clk after the frame tick.
  - This precedes the first BCLK falling edge, which is ≥2·BCLK_DIV clks after the tick.
  - The shift register is reloaded at the right-channel LRCK edge with the same sample.
- An event pulse at cycle t is pending at t+1. It is audible from the first frame tick at ≥t+1. Worst-case latency is one frame plus 1 clk.
- busy and active_event update on the frame tick cycle.

## Configuration
- AUDIO_ENVELOPE_EN:
  - **Defined:** amplitude decays. Magnitude = AMPLITUDE >> q, where q = floor(4·sample_cnt / TONE_SAMPLES), so q steps 0..3. It reloads to full on preemption or a new event.
  - **Undefined:** magnitude is constant AMPLITUDE and no envelope logic is built.

## Test plan
Bench parameters: NUM_EVENTS=5, BCLK_DIV=2, SAMPLE_WIDTH=16, AMPLITUDE=16'h2000, TONE_SAMPLES=8, HALF_BASE=2, HALF_STEP=1.

- **Idle after reset:** reset 3 clks, no events.
  - BCLK toggles every 2 clks; LRCK toggles every 128 clks.
  - aud_dacdat stays 0; busy=0.
- **Single event:** event_in[0] pulse.
  - From the next tick, busy=1 and active_event=0.
  - Decoded left/right samples are 2000,2000,E000,E000,2000,2000,E000,E000, then 0 with busy=0.
- **Priority:** simultaneous pulses on bits 1 and 3 plays event 3 first (half-period 5 frames), then event 1 for 8 frames.
- **Preemption and queueing:**
  - event_in[4] during an event-2 tone switches at the next tick to event 4 with sample 2000.
  - The pending[2] replay occurs only if event 2 was pulsed again.
- **Reset mid-tone:** reset during frame 3 of a tone gives all outputs at reset values. The queued event never plays.
- **Envelope (AUDIO_ENVELOPE_EN):** event 0 plays magnitudes 2000,2000,1000,1000,0800,0800,0400,0400 with the same signs as the single-event case.
